neuron_mac_pe: RTL and testbench
================================

# neuron_mac_pe

Parametrised neuron processing element for the digit-recognizer datapath. It accepts a stream of weight/input vector beats over a valid/ready handshake and pipelines the signed×unsigned products through a registered adder tree. The products feed a saturating accumulator, and at end-of-vector the block applies bias and a selectable activation (hard sigmoid or ReLU). It is the multi-beat, backpressure-aware successor of the fixed 4-lane sigmoid ALU, and sits between the weight/feature fetch logic and the layer output buffer.

## Interface
- LANES, 4, products per beat
- W_WIDTH, 4, signed weight width
- X_WIDTH, 4, unsigned input width
- ACC_WIDTH, 16, signed accumulator width (≥ W_WIDTH+X_WIDTH+clog2(LANES))
- FRAC_SHIFT, 2, arithmetic right shift applied to accumulator before bias
- OUT_WIDTH, 5, unsigned activation output width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat present
- in_ready  out  1  block can accept a beat
- in_last  in  1  beat is final one of the vector
- weights  in  LANES*W_WIDTH  packed signed weights, lane 0 in LSBs
- inputs  in  LANES*X_WIDTH  packed unsigned inputs, lane 0 in LSBs
- bias  in  W_WIDTH  signed bias, sampled in ACT state
- mode  in  1  0 = hard sigmoid, 1 = ReLU, sampled in ACT state
- out_valid  out  1  activation result available
- out_ready  in  1  consumer takes result
- out  out  OUT_WIDTH  activation result
- acc_out  out  ACC_WIDTH  current accumulator value
- sat  out  1  accumulator saturated at some point during the current vector (sticky)

## Operation
- Product: lane i = $signed(w_i) × unsigned x_i (x zero-extended by one bit), width W_WIDTH+X_WIDTH+1. Sum of all lanes is sign-extended to ACC_WIDTH.
- Stage 1: when a beat is accepted (in_valid & in_ready), the lane sum, a sum_valid flag, and a sum_last flag are registered.
- Stage 2: when sum_valid is set, acc ← sat(acc + sum). On saturation, acc clamps to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), and sat is set.
- FSM states:
  - ACCUM: in_ready=1. An accepted beat with in_last=1 moves the FSM to FLUSH.
  - FLUSH: in_ready=0. Lasts one cycle while the last sum enters acc. Next state ACT.
  - ACT: in_ready=0. Compute z = (acc >>> FRAC_SHIFT) + sign-ext(bias), at ACC_WIDTH+1 bits.
    - Sigmoid: y = clamp(z + 2^(OUT_WIDTH-1), 0, 2^OUT_WIDTH-1).
    - ReLU: y = clamp(z, 0, 2^OUT_WIDTH-1).
    - out ← y is registered. Next state HOLD.
  - HOLD: out_valid=1, in_ready=0. out, acc_out and sat stay stable. On out_ready=1: acc←0, sat←0, state→ACCUM.
- in_valid while in_ready=0 is ignored; no beat is consumed.
- A vector of length 1 (first beat carries in_last) is legal.
- Reset: state=ACCUM, acc=0, sum_valid=0, sat=0, out=0, out_valid=0, in_ready=0 during the rst cycle and 1 from the first cycle after. Reset mid-vector or in HOLD discards all partial data and any pending output.

## Timing
- Beat throughput: 1 per cycle in ACCUM.
- Latency: last beat accepted in cycle T → acc final after edge T+1 → out valid with out_valid=1 in cycle T+3.
- acc_out reflects each beat 2 edges after its acceptance.
- Minimum vector period: N beats + 3 cycles + result-wait cycles. The next vector's first beat can be accepted in the cycle after the out handshake.
- out_ready during non-HOLD states has no effect.

## Test plan
- Default params, one beat with weights all +1, inputs all 3, in_last=1, bias 0, mode 0 → acc_out=12, out=19, out_valid in cycle T+3. Same beat with mode 1 → out=3.
- Weights all -8, inputs all 15, one beat, mode 0 → acc_out=-480, out=0, sat=0. Bias +7 with weights +1/inputs 0, mode 1 → out=7.
- 80 consecutive beats with weights all +7 and inputs all 15 (420 per beat), last on beat 80 → acc_out=32767, sat=1, out=31 in both modes. sat returns to 0 after the handshake.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD → out, out_valid, acc_out stable, in_ready=0, in_valid beats are ignored. After out_ready=1, the next vector's result is independent of the ignored beats.
- Gapped input: 3 beats with in_valid deasserted for 2 cycles between each → same result as the back-to-back case.
- Assert rst for 1 cycle after 2 beats of a 4-beat vector → acc_out=0, out_valid=0. A fresh 1-beat vector then yields the single-beat result.

Source files
------------

// File: rtl/neuron_mac_pe.sv
// Neuron processing element: multi-lane signed x unsigned MAC with a registered lane sum,
// a saturating accumulator, then bias and hard-sigmoid/ReLU activation at end of vector.
module neuron_mac_pe #(
    parameter int LANES      = 4,
    parameter int W_WIDTH    = 4,
    parameter int X_WIDTH    = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int FRAC_SHIFT = 2,
    parameter int OUT_WIDTH  = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       in_last_i,
    input  logic [LANES*W_WIDTH-1:0]   weights_i,
    input  logic [LANES*X_WIDTH-1:0]   inputs_i,
    input  logic [W_WIDTH-1:0]         bias_i,
    input  logic                       mode_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [OUT_WIDTH-1:0]       out_o,
    output logic [ACC_WIDTH-1:0]       acc_out_o,
    output logic                       sat_o
);
    localparam int PW = W_WIDTH + X_WIDTH + 1;
    localparam int SW = PW + $clog2(LANES);
    localparam int ZW = ACC_WIDTH + 2;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ZW-1:0] OFFS = ZW'(1) << (OUT_WIDTH - 1);
    localparam logic signed [ZW-1:0] OMAX = (ZW'(1) << OUT_WIDTH) - ZW'(1);

    typedef enum logic [1:0] {ACCUM, FLUSH, ACT, HOLD} state_e;
    state_e state_q, state_d;

    logic signed [PW-1:0]        prod [LANES];
    logic signed [SW-1:0]        lane_sum;
    logic signed [ACC_WIDTH-1:0] sum_d, sum_q, acc_q, acc_sh;
    logic                        sum_valid_q, sat_q, accept;
    logic signed [ACC_WIDTH:0]   acc_sum;
    logic                        ovf;
    logic signed [ZW-1:0]        z, y_pre;
    logic [OUT_WIDTH-1:0]        y, out_q;

    // Input lanes are unsigned, so they get a zero MSB before the signed multiply.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign prod[g] = PW'($signed(weights_i[g*W_WIDTH +: W_WIDTH]))
                       * PW'($signed({1'b0, inputs_i[g*X_WIDTH +: X_WIDTH]}));
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SW'(prod[i]);
        end
    end

    assign sum_d   = ACC_WIDTH'(lane_sum);
    assign accept  = in_valid_i & in_ready_o;
    assign acc_sum = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(sum_q);
    assign ovf     = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1];

    assign acc_sh = acc_q >>> FRAC_SHIFT;
    assign z      = ZW'(acc_sh) + ZW'($signed(bias_i));
    assign y_pre  = mode_i ? z : z + OFFS;

    always_comb begin
        if (y_pre < 0)         y = '0;
        else if (y_pre > OMAX) y = '1;
        else                   y = y_pre[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready_o = ~rst_i;
                if (in_valid_i && !rst_i && in_last_i) state_d = FLUSH;
            end
            FLUSH: state_d = ACT;
            ACT:   state_d = HOLD;
            HOLD: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_valid_q <= 1'b0;
            sum_q       <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_q       <= '0;
        end else begin
            sum_valid_q <= accept;
            if (accept) sum_q <= sum_d;
            if (state_q == HOLD && out_ready_i) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end else if (sum_valid_q) begin
                if (ovf) begin
                    acc_q <= acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                    sat_q <= 1'b1;
                end else begin
                    acc_q <= acc_sum[ACC_WIDTH-1:0];
                end
            end
            if (state_q == ACT) out_q <= y;
        end
    end

    assign out_o     = out_q;
    assign acc_out_o = acc_q;
    assign sat_o     = sat_q;
endmodule

// File: tb/tb_neuron_mac_pe.sv
// Bench for neuron_mac_pe: per-vector reference results from plain integer arithmetic,
// checked on every cycle the result is presented, with directed and random vectors.
module tb_neuron_mac_pe;
    localparam int L = 4, W = 4, X = 4, A = 16, O = 5;

    logic             clk = 1'b0, rst = 1'b1;
    logic             in_valid = 1'b0, in_last = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [L*W-1:0]   weights = '0;
    logic [L*X-1:0]   inputs = '0;
    logic [W-1:0]     bias = '0;
    logic             in_ready, out_valid, sat;
    logic [O-1:0]     out;
    logic [A-1:0]     acc_out;

    neuron_mac_pe dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_last_i(in_last), .weights_i(weights), .inputs_i(inputs), .bias_i(bias),
        .mode_i(mode), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_o(out),
        .acc_out_o(acc_out), .sat_o(sat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [L*W-1:0] gw[$];
    logic [L*X-1:0] gx[$];
    typedef struct { int o; int a; bit s; } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: integer dot products, clamped running sum, then activation.
    function automatic exp_t model(input int b, input bit m);
        exp_t e;
        int acc = 0, z, y;
        bit s = 0;
        for (int i = 0; i < gw.size(); i++) begin
            int sum = 0;
            logic [L*W-1:0] wv = gw[i];
            logic [L*X-1:0] xv = gx[i];
            for (int l = 0; l < L; l++)
                sum += int'($signed(wv[l*W +: W])) * int'(xv[l*X +: X]);
            acc += sum;
            if (acc > 32767)  begin acc = 32767;  s = 1; end
            if (acc < -32768) begin acc = -32768; s = 1; end
        end
        z = (acc >>> 2) + b;
        y = m ? z : z + 16;
        if (y < 0)  y = 0;
        if (y > 31) y = 31;
        e.o = y; e.a = acc; e.s = s;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("out", int'(out), exp_q[0].o);
                chk("acc_out", int'($signed(acc_out)), exp_q[0].a);
                chk("sat", int'(sat), int'(exp_q[0].s));
                chk("in_ready_in_hold", int'(in_ready), 0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_vec(input int gap, input int hold, input logic [W-1:0] b, input logic m);
        int t, k;
        bit ok;
        exp_q.push_back(model(int'($signed(b)), m));
        @(posedge clk); #1;
        bias = b; mode = m;
        for (int i = 0; i < gw.size(); i++) begin
            in_valid = 1'b1; weights = gw[i]; inputs = gx[i]; in_last = (i == gw.size() - 1);
            t = 0;
            do begin
                @(negedge clk); ok = in_ready;
                @(posedge clk); #1; t++;
            end while (!ok && t < 50);
            if (!ok) chk("beat_accept_timeout", 0, 1);
            in_valid = 1'b0; in_last = 1'b0;
            if (i < gw.size() - 1) repeat (gap) begin @(posedge clk); #1; end
        end
        // Junk beats while the block is busy must be ignored.
        in_valid = 1'b1; weights = 16'($urandom); inputs = 16'($urandom); in_last = 1'($urandom);
        k = 0;
        do begin @(negedge clk); k++; end while (!out_valid && k < 10);
        chk("result_latency", k, 3);
        @(posedge clk); #1;
        repeat (hold) begin
            weights = 16'($urandom); inputs = 16'($urandom);
            bias = 4'($urandom); mode = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_acc", int'($signed(acc_out)), 0);
        chk("post_hs_sat", int'(sat), 0);
        chk("post_hs_valid", int'(out_valid), 0);
        chk("post_hs_ready", int'(in_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_acc", int'($signed(acc_out)), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_out", int'(out), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);

        gw = '{16'h1111}; gx = '{16'h3333};
        e = model(0, 0); chk("pin_sig_out", e.o, 19); chk("pin_sig_acc", e.a, 12);
        run_vec(0, 0, 4'd0, 1'b0);
        e = model(0, 1); chk("pin_relu_out", e.o, 3);
        run_vec(0, 2, 4'd0, 1'b1);

        gw = '{16'h8888}; gx = '{16'hFFFF};
        e = model(0, 0);
        chk("pin_neg_acc", e.a, -480); chk("pin_neg_out", e.o, 0); chk("pin_neg_sat", int'(e.s), 0);
        run_vec(0, 1, 4'd0, 1'b0);

        gw = '{16'h1111}; gx = '{16'h0000};
        e = model(7, 1); chk("pin_bias_out", e.o, 7);
        run_vec(0, 1, 4'd7, 1'b1);

        gw.delete(); gx.delete();
        repeat (80) begin gw.push_back(16'h7777); gx.push_back(16'hFFFF); end
        e = model(0, 0);
        chk("pin_sat_acc", e.a, 32767); chk("pin_sat_flag", int'(e.s), 1); chk("pin_sat_out", e.o, 31);
        e = model(0, 1); chk("pin_sat_relu_out", e.o, 31);
        run_vec(0, 5, 4'd0, 1'b0);
        run_vec(0, 0, 4'd0, 1'b1);

        gw.delete(); gx.delete();
        repeat (3) begin gw.push_back(16'($urandom)); gx.push_back(16'($urandom)); end
        run_vec(0, 0, 4'd3, 1'b1);
        run_vec(2, 0, 4'd3, 1'b1);

        // Reset two beats into a vector.
        @(posedge clk); #1;
        in_valid = 1'b1; weights = 16'h7777; inputs = 16'hFFFF; in_last = 1'b0;
        @(negedge clk); chk("midrst_beat0_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        @(negedge clk); chk("midrst_beat1_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); chk("midrst_ready_low", int'(in_ready), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_acc", int'($signed(acc_out)), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_sat", int'(sat), 0);
        @(negedge clk);
        chk("midrst_acc_flushed", int'($signed(acc_out)), 0);
        gw = '{16'h1111}; gx = '{16'h3333};
        run_vec(0, 0, 4'd0, 1'b0);

        for (int v = 0; v < 25; v++) begin
            int n = $urandom_range(1, 6);
            gw.delete(); gx.delete();
            repeat (n) begin gw.push_back(16'($urandom)); gx.push_back(16'($urandom)); end
            run_vec($urandom_range(0, 2), $urandom_range(0, 3), 4'($urandom), 1'($urandom));
        end

        repeat (5) @(posedge clk);
        chk("pending_results", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
